// File: rtl/icb_sram_responder_if.sv
// ICB command/response bundle between a memory master (e.g. the MMA LSU)
// and an SRAM responder.
interface icb_sram_responder_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [ADDR_WIDTH-1:0]     cmd_addr;
    logic                      cmd_read;
    logic [DATA_WIDTH-1:0]     cmd_wdata;
    logic [DATA_WIDTH/8-1:0]   cmd_wmask;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_WIDTH-1:0]     rsp_rdata;
    logic                      rsp_err;

    modport master (
        output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/icb_sram_responder.sv
// ICB responder backed by a word-addressed SRAM: one-cycle read latency,
// in-order responses through a small queue that absorbs rsp_ready backpressure.

module icb_sram_responder_chk #(
    parameter int unsigned RSP_DEPTH = 2,
    parameter int unsigned OCC_W     = 2
) (
    input logic             clk_i,
    input logic             rst_ni,
    input logic             rsp_valid_i,
    input logic             rsp_ready_i,
    input logic [OCC_W-1:0] occ_i
);
    // a presented response stays up until it is taken
    a_rsp_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (rsp_valid_i && !rsp_ready_i) |=> rsp_valid_i);

    // occupancy never exceeds the queue capacity
    a_occ_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
        occ_i <= OCC_W'(RSP_DEPTH));
endmodule

module icb_sram_responder #(
    parameter int unsigned             ADDR_WIDTH  = 32,
    parameter int unsigned             DATA_WIDTH  = 32,
    parameter int unsigned             DEPTH_WORDS = 4096,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR   = '0,
    parameter int unsigned             RSP_DEPTH   = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    icb_sram_responder_if.slave icb_s
);
    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned OCC_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(RSP_DEPTH);
    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(DEPTH_WORDS * 4);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
    } rsp_t;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
    rsp_t                  fifo_q [RSP_DEPTH];

    logic [ADDR_WIDTH-1:0] offset_s;
    logic [IDX_W-1:0]      idx_s;
    logic                  addr_err_s;
    logic [DATA_WIDTH-1:0] rd_word_s;
    logic                  cmd_hs_s;
    logic                  rsp_valid_s;
    logic                  rsp_hs_s;
    logic                  push_s;
    logic                  pop_s;
    rsp_t                  head_s;

    logic [OCC_W-1:0] occ_q, occ_d;
    logic [OCC_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             cmd_ready_q;
    logic             pipe_vld_q;
    rsp_t             pipe_q;

    // address decode and SRAM read word
    always_comb begin
        offset_s   = icb_s.cmd_addr - BASE_ADDR;
        idx_s      = offset_s[IDX_W+1:2];
        addr_err_s = (icb_s.cmd_addr < BASE_ADDR) || (offset_s >= SPAN) ||
                     (icb_s.cmd_addr[1:0] != 2'b00);
        if (icb_s.cmd_read && !addr_err_s) begin
            rd_word_s = mem_q[idx_s];
        end else begin
            rd_word_s = '0;
        end
    end

    // handshakes; the pipeline stage answers directly when the queue is empty
    always_comb begin
        cmd_hs_s    = icb_s.cmd_valid && cmd_ready_q;
        rsp_valid_s = pipe_vld_q || (cnt_q != '0);
        rsp_hs_s    = rsp_valid_s && icb_s.rsp_ready;
        pop_s       = (cnt_q != '0) && icb_s.rsp_ready;
        push_s      = pipe_vld_q && !((cnt_q == '0) && icb_s.rsp_ready);
        if (cnt_q != '0) begin
            head_s = fifo_q[rd_ptr_q];
        end else begin
            head_s = pipe_q;
        end
    end

    // occupancy and queue pointer next-state
    always_comb begin
        occ_d    = occ_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (cmd_hs_s && !rsp_hs_s) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!cmd_hs_s && rsp_hs_s) begin
            occ_d = occ_q - OCC_W'(1);
        end else begin
            occ_d = occ_q;
        end
        if (push_s && !pop_s) begin
            cnt_d = cnt_q + OCC_W'(1);
        end else if (pop_s && !push_s) begin
            cnt_d = cnt_q - OCC_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        if (push_s) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // control state, read pipeline and registered command ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q       <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cmd_ready_q <= 1'b0;
            pipe_vld_q  <= 1'b0;
            pipe_q      <= '0;
        end else begin
            occ_q       <= occ_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cmd_ready_q <= (occ_d < OCC_W'(RSP_DEPTH));
            pipe_vld_q  <= cmd_hs_s;
            if (cmd_hs_s) begin
                pipe_q <= '{rdata: rd_word_s, err: addr_err_s};
            end
        end
    end

    // response queue storage
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_q[wr_ptr_q] <= pipe_q;
        end
    end

    // byte-masked SRAM write; contents survive reset
    always_ff @(posedge clk) begin
        if (cmd_hs_s && !icb_s.cmd_read && !addr_err_s) begin
            for (int b = 0; b < NB; b++) begin
                if (icb_s.cmd_wmask[b]) begin
                    mem_q[idx_s][8*b +: 8] <= icb_s.cmd_wdata[8*b +: 8];
                end
            end
        end
    end

    assign icb_s.cmd_ready = cmd_ready_q;
    assign icb_s.rsp_valid = rsp_valid_s;
    assign icb_s.rsp_rdata = head_s.rdata;
    assign icb_s.rsp_err   = head_s.err;

    icb_sram_responder_chk #(
        .RSP_DEPTH (RSP_DEPTH),
        .OCC_W     (OCC_W)
    ) u_chk (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rsp_valid_i (rsp_valid_s),
        .rsp_ready_i (icb_s.rsp_ready),
        .occ_i       (occ_q)
    );
endmodule

// File: tb/tb_icb_sram_responder.sv
// Directed and randomized bench for icb_sram_responder with a queue-based
// reference model of the memory and the expected response stream.
module tb_icb_sram_responder;
    localparam int unsigned DEPTH = 4096;
    localparam int unsigned RSPD  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    icb_sram_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) icb ();

    icb_sram_responder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH),
        .BASE_ADDR(32'h0000_0000), .RSP_DEPTH(RSPD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .icb_s (icb.slave)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int cmd_hs_cnt = 0;
    int last_wait = 0;
    bit mon_en = 1'b0;

    logic [31:0] mdl_mem [DEPTH];
    logic [31:0] exp_d [$];
    logic        exp_e [$];
    logic [31:0] log_d [$];
    int          log_c [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    always @(posedge clk) cyc++;

    // reference model: sampled mid-cycle, so handshakes seen here occur at the next edge
    always @(negedge clk) begin
        if (mon_en) begin
            chk("cmd_ready_vs_occ", 32'(icb.cmd_ready), 32'(exp_d.size() < RSPD));
            chk("rsp_valid_vs_pending", 32'(icb.rsp_valid), 32'(exp_d.size() != 0));
            if (icb.rsp_valid && icb.rsp_ready && exp_d.size() != 0) begin
                chk("rsp_rdata", icb.rsp_rdata, exp_d[0]);
                chk("rsp_err", 32'(icb.rsp_err), 32'(exp_e[0]));
                log_d.push_back(icb.rsp_rdata);
                log_c.push_back(cyc);
                void'(exp_d.pop_front());
                void'(exp_e.pop_front());
            end
            if (icb.cmd_valid && icb.cmd_ready) begin
                longint unsigned a;
                bit bad;
                int w;
                cmd_hs_cnt++;
                a   = longint'(icb.cmd_addr);
                bad = (a >= longint'(DEPTH) * 4) || (a % 4 != 0);
                w   = int'(a / 4);
                if (icb.cmd_read) begin
                    exp_d.push_back(bad ? 32'h0 : mdl_mem[w]);
                end else begin
                    if (!bad) begin
                        for (int b = 0; b < 4; b++) begin
                            if (icb.cmd_wmask[b]) mdl_mem[w][8*b +: 8] = icb.cmd_wdata[8*b +: 8];
                        end
                    end
                    exp_d.push_back(32'h0);
                end
                exp_e.push_back(bad);
            end
        end
    end

    task automatic issue(input logic rd, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm);
        bit acc = 1'b0;
        icb.cmd_valid = 1'b1;
        icb.cmd_read  = rd;
        icb.cmd_addr  = a;
        icb.cmd_wdata = wd;
        icb.cmd_wmask = wm;
        last_wait = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (icb.cmd_ready) begin
                acc = 1'b1;
                break;
            end
            last_wait++;
        end
        @(posedge clk); #1;
        icb.cmd_valid = 1'b0;
        chk("cmd_accept", 32'(acc), 32'd1);
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (exp_d.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain", 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int maxw;
        int hs0;
        int npop;
        icb.cmd_valid = 1'b0; icb.cmd_read = 1'b0; icb.cmd_addr = 32'h0;
        icb.cmd_wdata = 32'h0; icb.cmd_wmask = 4'h0; icb.rsp_ready = 1'b1;

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(icb.cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(icb.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", icb.rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(icb.rsp_err), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_cmd_ready", 32'(icb.cmd_ready), 32'd1);
        @(posedge clk); #1;
        mon_en = 1'b1;

        // full write then read with one-cycle latency
        issue(1'b0, 32'h10, 32'hDEAD_BEEF, 4'hF);
        wait_drain();
        issue(1'b1, 32'h10, 32'h0, 4'h0);
        @(negedge clk);
        chk("rd_latency_valid", 32'(icb.rsp_valid), 32'd1);
        chk("rd_deadbeef", icb.rsp_rdata, 32'hDEAD_BEEF);
        chk("rd_deadbeef_err", 32'(icb.rsp_err), 32'd0);
        wait_drain();

        // byte-masked merge; read issued right after the write
        issue(1'b0, 32'h20, 32'h1122_3344, 4'hF);
        issue(1'b0, 32'h20, 32'hAABB_CCDD, 4'b0101);
        issue(1'b1, 32'h20, 32'h0, 4'h0);
        @(negedge clk);
        chk("rd_merge", icb.rsp_rdata, 32'h11BB_33DD);
        wait_drain();

        // back-to-back reads of words 0..7
        for (int i = 0; i < 8; i++) issue(1'b0, 32'(i * 4), 32'(i), 4'hF);
        wait_drain();
        base = log_d.size();
        maxw = 0;
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, 32'(i * 4), 32'h0, 4'h0);
            if (last_wait > maxw) maxw = last_wait;
        end
        wait_drain();
        chk("b2b_ready_stall", 32'(maxw), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk("b2b_order", log_d[base + i], 32'(i));
            chk("b2b_consecutive", 32'(log_c[base + i] - log_c[base]), 32'(i));
        end

        // backpressure fills the queue
        icb.rsp_ready = 1'b0;
        hs0 = cmd_hs_cnt;
        icb.cmd_valid = 1'b1; icb.cmd_read = 1'b1; icb.cmd_addr = 32'h14;
        repeat (6) begin @(posedge clk); #1; end
        chk("bp_accepted", 32'(cmd_hs_cnt - hs0), 32'(RSPD));
        @(negedge clk);
        chk("bp_full_ready", 32'(icb.cmd_ready), 32'd0);
        @(posedge clk); #1;
        icb.cmd_valid = 1'b0;
        icb.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_before_pop", 32'(icb.cmd_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_ready_after_pop", 32'(icb.cmd_ready), 32'd1);
        wait_drain();

        // error accesses, including writes that alias word 0 if decoded carelessly
        issue(1'b1, 32'(DEPTH * 4), 32'h0, 4'h0);
        @(negedge clk);
        chk("err_oor_flag", 32'(icb.rsp_err), 32'd1);
        chk("err_oor_rdata", icb.rsp_rdata, 32'h0);
        wait_drain();
        issue(1'b1, 32'h2, 32'h0, 4'h0);
        @(negedge clk);
        chk("err_misalign_flag", 32'(icb.rsp_err), 32'd1);
        chk("err_misalign_rdata", icb.rsp_rdata, 32'h0);
        wait_drain();
        issue(1'b0, 32'(DEPTH * 4), 32'hFFFF_FFFF, 4'hF);
        issue(1'b0, 32'h1, 32'hFFFF_FFFF, 4'hF);
        issue(1'b0, 32'h4, 32'h1234_5678, 4'h0);
        issue(1'b1, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("err_write_no_effect", icb.rsp_rdata, 32'h0);
        wait_drain();
        issue(1'b1, 32'h4, 32'h0, 4'h0);
        @(negedge clk);
        chk("mask0_no_effect", icb.rsp_rdata, 32'h1);
        wait_drain();

        // randomized traffic over words 0..15 plus error addresses
        for (int i = 9; i < 16; i++) issue(1'b0, 32'(i * 4), $urandom, 4'hF);
        wait_drain();
        npop = log_d.size();
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 15));
            icb.cmd_valid = ($urandom_range(0, 3) != 0);
            icb.cmd_read  = $urandom_range(0, 1) == 1;
            if (r == 0)      icb.cmd_addr = 32'(DEPTH * 4) + 32'($urandom_range(0, 15) * 4);
            else if (r == 1) icb.cmd_addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else             icb.cmd_addr = 32'($urandom_range(0, 15) * 4);
            icb.cmd_wdata = $urandom;
            icb.cmd_wmask = 4'($urandom_range(0, 15));
            icb.rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        icb.cmd_valid = 1'b0;
        icb.rsp_ready = 1'b1;
        wait_drain();
        chk("rand_traffic_flowed", 32'(log_d.size() - npop > 100), 32'd1);

        // reset with two responses pending; a committed write survives
        icb.rsp_ready = 1'b0;
        issue(1'b0, 32'hC, 32'h5A5A_5A5A, 4'hF);
        issue(1'b1, 32'h4, 32'h0, 4'h0);
        mon_en = 1'b0;
        exp_d.delete();
        exp_e.delete();
        @(negedge clk);
        chk("pre_rst_valid", 32'(icb.rsp_valid), 32'd1);
        chk("pre_rst_full", 32'(icb.cmd_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(icb.rsp_valid), 32'd0);
        chk("mid_rst_ready", 32'(icb.cmd_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst2_ready", 32'(icb.cmd_ready), 32'd1);
        chk("post_rst2_no_stale", 32'(icb.rsp_valid), 32'd0);
        @(posedge clk); #1;
        icb.rsp_ready = 1'b1;
        mon_en = 1'b1;
        issue(1'b1, 32'hC, 32'h0, 4'h0);
        @(negedge clk);
        chk("rst_keeps_sram", icb.rsp_rdata, 32'h5A5A_5A5A);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
